// File: rtl/mac_tx_pls_serializer_pkg.sv
// Shared PLS primitive encodings, framing constants and serializer state type.
package mac_tx_pls_serializer_pkg;

  localparam logic [4:0] PLS_NONE    = 5'b00000;
  localparam logic [4:0] PLS_ZERO    = 5'b00001;
  localparam logic [4:0] PLS_ONE     = 5'b00010;
  localparam logic [4:0] PLS_EXT_ERR = 5'b00100;
  localparam logic [4:0] PLS_EXT     = 5'b01000;
  localparam logic [4:0] PLS_DONE    = 5'b10000;

  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_EXTEND,
    ST_UNDERRUN,
    ST_JAM,
    ST_FLUSH,
    ST_COMPLETE,
    ST_IFG
  } tx_state_e;

  function automatic logic [4:0] bit_to_pls(input logic b);
    return b ? PLS_ONE : PLS_ZERO;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mac_tx_pls_serializer_shifter.sv
// Byte shift register for the DATA phase. Bit 0 of a byte is presented by the
// parent at load time, so only bits 7:1 are held here; cur_bit is the next bit
// still waiting to be presented and last_bit flags that bit 7 is on the line.
module tx_byte_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [6:0] load_bits,
  output logic       cur_bit,
  output logic       last_bit
);

  logic [6:0] pending;
  logic [2:0] bit_idx;

  // Load a new byte or advance one bit position.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= '0;
      bit_idx <= '0;
    end else if (load) begin
      pending <= load_bits;
      bit_idx <= '0;
    end else if (shift) begin
      pending <= {1'b0, pending[6:1]};
      bit_idx <= bit_idx + 3'd1;
    end
  end

  assign cur_bit  = pending[0];
  assign last_bit = (bit_idx == 3'd7);

endmodule

// File: rtl/mac_tx_pls_serializer.sv
// MAC transmit bit serializer: frames bytes into PLS_DATA.request primitives
// (preamble, SFD, data, extension, DATA_COMPLETE), with defer and collision jam.
module mac_tx_pls_serializer
  import mac_tx_pls_serializer_pkg::*;
#(
  parameter int unsigned PREAMBLE_BYTES = 7,
  parameter int unsigned MIN_FRAME_BITS = 512,
  parameter int unsigned JAM_BITS       = 32,
  parameter int unsigned IFG_CYCLES     = 96
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  input  logic       pls_carrier_indication,
  input  logic       pls_signal_indication,
  output logic [4:0] pls_data_request,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_collision,
  output logic       tx_error
);

  localparam int unsigned PRE_BITS = 8 * PREAMBLE_BYTES;
  localparam int unsigned CNT_MAX  = max_u(max_u(PRE_BITS - 1, JAM_BITS - 1),
                                           max_u(IFG_CYCLES - 1, 7));
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned SLOT_W   = $clog2(MIN_FRAME_BITS + 1);

  tx_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [SLOT_W-1:0] slot_cnt;
  logic              slot_full;
  logic              cur_last;
  logic              last_seen;
  logic              accept;
  logic              collide;
  logic              sh_load;
  logic              sh_shift;
  logic              sh_cur_bit;
  logic              sh_last_bit;

  assign cnt_nxt   = cnt + CNT_W'(1);
  // slot_cnt counts slot bits before the one on the line; full once this bit completes the slot
  assign slot_full = (slot_cnt >= SLOT_W'(MIN_FRAME_BITS - 1));

  // Ready is decoded from the state of the bit currently on the line.
  always_comb begin
    tx_ready = 1'b0;
    case (state)
      ST_SFD:            tx_ready = (cnt == CNT_W'(7));
      ST_DATA:           tx_ready = sh_last_bit && !cur_last;
      ST_JAM, ST_FLUSH:  tx_ready = 1'b1;
      default:           tx_ready = 1'b0;
    endcase
    tx_ready = tx_ready && reset;
  end

  assign accept   = tx_ready && tx_valid;
  assign collide  = pls_signal_indication &&
                    ((state == ST_PREAMBLE) || (state == ST_SFD) || (state == ST_DATA) ||
                     (state == ST_EXTEND) || (state == ST_UNDERRUN));
  assign sh_load  = accept && ((state == ST_SFD) || (state == ST_DATA));
  assign sh_shift = (state == ST_DATA) && !sh_last_bit;

  tx_byte_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_bits (tx_byte[7:1]),
    .cur_bit   (sh_cur_bit),
    .last_bit  (sh_last_bit)
  );

  // Main FSM: state always describes the primitive being driven this clk,
  // so each transition also registers the first primitive of the new state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      slot_cnt         <= '0;
      cur_last         <= 1'b0;
      last_seen        <= 1'b0;
      pls_data_request <= PLS_NONE;
      tx_busy          <= 1'b0;
      tx_done          <= 1'b0;
      tx_collision     <= 1'b0;
      tx_error         <= 1'b0;
    end else begin
      tx_done      <= 1'b0;
      tx_collision <= 1'b0;
      tx_error     <= 1'b0;
      if (accept && tx_last) last_seen <= 1'b1;

      if (collide) begin
        state            <= ST_JAM;
        cnt              <= '0;
        pls_data_request <= PLS_ONE;
        tx_busy          <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (tx_valid && !pls_carrier_indication) begin
              state            <= ST_PREAMBLE;
              cnt              <= '0;
              slot_cnt         <= '0;
              cur_last         <= 1'b0;
              last_seen        <= 1'b0;
              pls_data_request <= bit_to_pls(PREAMBLE_BYTE[0]);
              tx_busy          <= 1'b1;
            end
          end

          ST_PREAMBLE: begin
            if (cnt == CNT_W'(PRE_BITS - 1)) begin
              state            <= ST_SFD;
              cnt              <= '0;
              pls_data_request <= bit_to_pls(SFD_BYTE[0]);
            end else begin
              cnt              <= cnt_nxt;
              pls_data_request <= bit_to_pls(PREAMBLE_BYTE[cnt_nxt[2:0]]);
            end
          end

          ST_SFD: begin
            if (cnt == CNT_W'(7)) begin
              cnt <= '0;
              if (tx_valid) begin
                state            <= ST_DATA;
                cur_last         <= tx_last;
                pls_data_request <= bit_to_pls(tx_byte[0]);
              end else begin
                state            <= ST_UNDERRUN;
                pls_data_request <= PLS_EXT_ERR;
              end
            end else begin
              cnt              <= cnt_nxt;
              pls_data_request <= bit_to_pls(SFD_BYTE[cnt_nxt[2:0]]);
            end
          end

          ST_DATA: begin
            if (slot_cnt != SLOT_W'(MIN_FRAME_BITS)) slot_cnt <= slot_cnt + SLOT_W'(1);
            if (!sh_last_bit) begin
              pls_data_request <= bit_to_pls(sh_cur_bit);
            end else if (cur_last) begin
              if (slot_full) begin
                state            <= ST_COMPLETE;
                pls_data_request <= PLS_DONE;
                tx_done          <= 1'b1;
              end else begin
                state            <= ST_EXTEND;
                pls_data_request <= PLS_EXT;
              end
            end else if (tx_valid) begin
              cur_last         <= tx_last;
              pls_data_request <= bit_to_pls(tx_byte[0]);
            end else begin
              state            <= ST_UNDERRUN;
              cnt              <= '0;
              pls_data_request <= PLS_EXT_ERR;
            end
          end

          ST_EXTEND: begin
            if (slot_cnt != SLOT_W'(MIN_FRAME_BITS)) slot_cnt <= slot_cnt + SLOT_W'(1);
            if (slot_full) begin
              state            <= ST_COMPLETE;
              pls_data_request <= PLS_DONE;
              tx_done          <= 1'b1;
            end else begin
              pls_data_request <= PLS_EXT;
            end
          end

          ST_UNDERRUN: begin
            if (cnt == CNT_W'(7)) begin
              state            <= ST_COMPLETE;
              pls_data_request <= PLS_DONE;
              tx_error         <= 1'b1;
            end else begin
              cnt              <= cnt_nxt;
              pls_data_request <= PLS_EXT_ERR;
            end
          end

          ST_JAM: begin
            if (cnt == CNT_W'(JAM_BITS - 1)) begin
              if (last_seen || (accept && tx_last)) begin
                state            <= ST_COMPLETE;
                pls_data_request <= PLS_DONE;
                tx_collision     <= 1'b1;
              end else begin
                state            <= ST_FLUSH;
                pls_data_request <= PLS_NONE;
              end
            end else begin
              cnt              <= cnt_nxt;
              pls_data_request <= cnt_nxt[0] ? PLS_ZERO : PLS_ONE;
            end
          end

          ST_FLUSH: begin
            if (tx_valid && tx_last) begin
              state            <= ST_COMPLETE;
              pls_data_request <= PLS_DONE;
              tx_collision     <= 1'b1;
            end else begin
              pls_data_request <= PLS_NONE;
            end
          end

          ST_COMPLETE: begin
            state            <= ST_IFG;
            cnt              <= '0;
            pls_data_request <= PLS_NONE;
          end

          ST_IFG: begin
            pls_data_request <= PLS_NONE;
            if (cnt == CNT_W'(IFG_CYCLES - 1)) begin
              state   <= ST_IDLE;
              cnt     <= '0;
              tx_busy <= 1'b0;
            end else begin
              cnt <= cnt_nxt;
            end
          end

          default: begin
            state            <= ST_IDLE;
            pls_data_request <= PLS_NONE;
            tx_busy          <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_tx_pls_serializer.sv
// Self-checking bench for mac_tx_pls_serializer with MIN_FRAME_BITS=64.
module tb_mac_tx_pls_serializer;

  localparam int PRE_BYTES = 7;
  localparam int MIN_BITS  = 64;
  localparam int JAM_LEN   = 32;
  localparam int IFG_LEN   = 96;

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_ZERO = 5'b00001;
  localparam logic [4:0] S_ONE  = 5'b00010;
  localparam logic [4:0] S_EERR = 5'b00100;
  localparam logic [4:0] S_EXT  = 5'b01000;
  localparam logic [4:0] S_DONE = 5'b10000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       pls_carrier_indication;
  logic       pls_signal_indication;
  logic [4:0] pls_data_request;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_collision;
  logic       tx_error;

  always #5 clk = ~clk;

  mac_tx_pls_serializer #(
    .PREAMBLE_BYTES (PRE_BYTES),
    .MIN_FRAME_BITS (MIN_BITS),
    .JAM_BITS       (JAM_LEN),
    .IFG_CYCLES     (IFG_LEN)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .tx_byte                (tx_byte),
    .tx_valid               (tx_valid),
    .tx_last                (tx_last),
    .tx_ready               (tx_ready),
    .pls_carrier_indication (pls_carrier_indication),
    .pls_signal_indication  (pls_signal_indication),
    .pls_data_request       (pls_data_request),
    .tx_busy                (tx_busy),
    .tx_done                (tx_done),
    .tx_collision           (tx_collision),
    .tx_error               (tx_error)
  );

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       done;
    logic       coll;
    logic       err;
    logic [4:0] req;
  } obs_t;

  typedef struct {
    int         len;
    logic [7:0] base;
    logic [7:0] step;
    int         underrun_k;
    int         coll_c;
    int         defer;
    int         exp_ext;
    int         exp_eerr;
    int         exp_done;
    int         exp_coll;
    int         exp_err;
  } vec_t;

  obs_t exp_q[$];
  int unsigned checks = 0;
  int unsigned passes = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, req);
  endtask

  function automatic obs_t mk(input logic [4:0] s, input logic rdy);
    obs_t o;
    o       = '0;
    o.req   = s;
    o.busy  = 1'b1;
    o.ready = rdy;
    return o;
  endfunction

  // Reference: the whole primitive stream of one frame, from first preamble bit to the idle clk after IFG.
  task automatic build_expected(input logic [7:0] frame[$], input int underrun_k, input int coll_c);
    logic [7:0] sfd;
    logic [7:0] cur;
    int   n, sent, acc, remaining, outcome;
    obs_t e;
    exp_q.delete();
    n   = frame.size();
    sfd = 8'hD5;
    for (int k = 0; k < 8 * PRE_BYTES; k++) exp_q.push_back(mk((k % 2 == 0) ? S_ONE : S_ZERO, 1'b0));
    for (int b = 0; b < 8; b++) exp_q.push_back(mk(sfd[b] ? S_ONE : S_ZERO, b == 7));
    sent = (underrun_k >= 0) ? underrun_k + 1 : n;
    for (int i = 0; i < sent; i++) begin
      cur = frame[i];
      for (int b = 0; b < 8; b++) exp_q.push_back(mk(cur[b] ? S_ONE : S_ZERO, (b == 7) && (i != n - 1)));
    end
    if (underrun_k >= 0) begin
      for (int k = 0; k < 8; k++) exp_q.push_back(mk(S_EERR, 1'b0));
      outcome = 2;
    end else begin
      for (int k = 8 * n; k < MIN_BITS; k++) exp_q.push_back(mk(S_EXT, 1'b0));
      outcome = 0;
    end
    if (coll_c >= 0) begin
      acc = 0;
      for (int i = 0; i <= coll_c; i++) if (exp_q[i].ready) acc++;
      remaining = n - acc;
      while (exp_q.size() > coll_c + 1) void'(exp_q.pop_back());
      for (int j = 0; j < JAM_LEN; j++) exp_q.push_back(mk((j % 2 == 0) ? S_ONE : S_ZERO, 1'b1));
      for (int j = 0; j < remaining - JAM_LEN; j++) exp_q.push_back(mk(S_NONE, 1'b1));
      outcome = 1;
    end
    e      = mk(S_DONE, 1'b0);
    e.done = (outcome == 0);
    e.coll = (outcome == 1);
    e.err  = (outcome == 2);
    exp_q.push_back(e);
    for (int k = 0; k < IFG_LEN; k++) exp_q.push_back(mk(S_NONE, 1'b0));
    e = '0;
    exp_q.push_back(e);
  endtask

  // Drives one frame (byte source follows tx_ready) and compares every clk against the reference.
  task automatic run_frame(input logic [7:0] frame[$], input int underrun_k, input int coll_c, input int defer,
                           output int n_ext, output int n_eerr, output int n_done, output int n_coll, output int n_err);
    int   ptr, done_idx, n;
    logic acc;
    obs_t got;
    build_expected(frame, underrun_k, coll_c);
    n        = frame.size();
    ptr      = 0;
    done_idx = 0;
    for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].req == S_DONE) done_idx = i;
    n_ext = 0; n_eerr = 0; n_done = 0; n_coll = 0; n_err = 0;
    tx_valid               = 1'b1;
    tx_byte                = frame[0];
    tx_last                = (n == 1);
    pls_signal_indication  = 1'b0;
    pls_carrier_indication = (defer > 0);
    for (int j = 0; j < defer; j++) begin
      @(posedge clk); #1;
      check("defer_idle", j, {25'd0, tx_busy, tx_ready, pls_data_request}, 32'd0);
      if (j == defer - 1) pls_carrier_indication = 1'b0;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      acc = tx_ready && tx_valid;
      @(posedge clk); #1;
      if (acc) ptr++;
      got.ready = tx_ready;
      got.busy  = tx_busy;
      got.done  = tx_done;
      got.coll  = tx_collision;
      got.err   = tx_error;
      got.req   = pls_data_request;
      check("stream", i, 32'(got), 32'(exp_q[i]));
      if (got.req == S_EXT)  n_ext++;
      if (got.req == S_EERR) n_eerr++;
      if (got.done) n_done++;
      if (got.coll) n_coll++;
      if (got.err)  n_err++;
      if (i >= done_idx) begin
        // after DATA_COMPLETE: noise on every input the block must ignore
        tx_valid               = (i < exp_q.size() - 1);
        tx_byte                = 8'($urandom);
        tx_last                = 1'b1;
        pls_signal_indication  = 1'($urandom);
        pls_carrier_indication = 1'($urandom);
      end else begin
        tx_valid = (ptr < n) && !((underrun_k >= 0) && (ptr > underrun_k));
        if (ptr < n) tx_byte = frame[ptr];
        tx_last               = (ptr == n - 1);
        pls_signal_indication = (i == coll_c);
      end
    end
    tx_valid               = 1'b0;
    tx_last                = 1'b0;
    pls_signal_indication  = 1'b0;
    pls_carrier_indication = 1'b0;
  endtask

  vec_t tbl[10];
  logic [7:0] fr[$];
  logic [7:0] b8;
  int ne, nee, nd, nc, nr;
  int rn, mode, uk, cc, df;

  initial begin
    // len base step underrun coll defer | ext eerr done coll err
    tbl[0] = '{1,  8'hA5, 8'h00, -1, -1,  0, 56, 0, 1, 0, 0};
    tbl[1] = '{9,  8'h00, 8'h01, -1, -1,  0,  0, 0, 1, 0, 0};
    tbl[2] = '{1,  8'hA5, 8'h00, -1, -1, 10, 56, 0, 1, 0, 0};
    tbl[3] = '{5,  8'h10, 8'h11, -1, 83,  0,  0, 0, 0, 1, 0};
    tbl[4] = '{3,  8'hC3, 8'h05,  1, -1,  0,  0, 8, 0, 0, 1};
    tbl[5] = '{8,  8'hF0, 8'h01, -1, -1,  0,  0, 0, 1, 0, 0};
    tbl[6] = '{7,  8'h81, 8'h02, -1, -1,  0,  8, 0, 1, 0, 0};
    tbl[7] = '{40, 8'h00, 8'h03, -1,  5,  0,  0, 0, 0, 1, 0};
    tbl[8] = '{2,  8'h3C, 8'h01, -1, 90,  0, 11, 0, 0, 1, 0};
    tbl[9] = '{1,  8'h7E, 8'h00, -1, 63,  0,  0, 0, 0, 1, 0};

    reset                  = 1'b0;
    tx_byte                = '0;
    tx_valid               = 1'b0;
    tx_last                = 1'b0;
    pls_carrier_indication = 1'b0;
    pls_signal_indication  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 0, {22'd0, tx_ready, tx_busy, tx_done, tx_collision, tx_error, pls_data_request}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 10; t++) begin
      fr.delete();
      b8 = tbl[t].base;
      for (int k = 0; k < tbl[t].len; k++) begin
        fr.push_back(b8);
        b8 = b8 + tbl[t].step;
      end
      run_frame(fr, tbl[t].underrun_k, tbl[t].coll_c, tbl[t].defer, ne, nee, nd, nc, nr);
      check("ext_count",  t, ne,  tbl[t].exp_ext);
      check("eerr_count", t, nee, tbl[t].exp_eerr);
      check("done_count", t, nd,  tbl[t].exp_done);
      check("coll_count", t, nc,  tbl[t].exp_coll);
      check("err_count",  t, nr,  tbl[t].exp_err);
    end

    // reset pulse in the middle of DATA, then a clean frame
    tx_valid = 1'b1;
    tx_last  = 1'b0;
    tx_byte  = 8'h5A;
    repeat (75) @(posedge clk);
    #1;
    check("mid_data_bit", 0, pls_data_request, S_ZERO);
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_mid_data", 0, {22'd0, tx_ready, tx_busy, tx_done, tx_collision, tx_error, pls_data_request}, 32'd0);
    reset    = 1'b1;
    tx_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", 0, {22'd0, tx_ready, tx_busy, pls_data_request}, 32'd0);
    fr.delete();
    fr.push_back(8'h12);
    fr.push_back(8'h34);
    run_frame(fr, -1, -1, 0, ne, nee, nd, nc, nr);
    check("post_reset_done", 0, nd, 1);
    check("post_reset_ext",  0, ne, 48);

    // randomized frames against the reference stream
    for (int r = 0; r < 10; r++) begin
      rn = $urandom_range(1, 12);
      fr.delete();
      for (int k = 0; k < rn; k++) fr.push_back(8'($urandom));
      mode = $urandom_range(0, 2);
      uk   = -1;
      cc   = -1;
      df   = $urandom_range(0, 3);
      if (mode == 1) cc = $urandom_range(0, 64 + ((8 * rn > MIN_BITS) ? 8 * rn : MIN_BITS) - 1);
      if (mode == 2 && rn >= 2) uk = $urandom_range(0, rn - 2);
      run_frame(fr, uk, cc, df, ne, nee, nd, nc, nr);
      check("rand_outcome", r, nd + nc + nr, 1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
